control_unit: RTL and testbench

- Moore FSM that sequences the K&S processor.
- Drives every control input of the datapath: PC, IR, address mux, C-bus mux, ALU operation, register-file write, flags-register write.
- Consumes the datapath's decoded instruction and registered flags.
- Issues the RAM write strobe and a halt indication to the top level.

---
 rtl/k_and_s_pkg.sv | 69 ++++++
 rtl/branch_eval.sv | 33 +++
 rtl/control_unit.sv | 166 ++++++++++++++++
 tb/tb_control_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
// K&S processor shared types: instruction decode, control states, ALU ops.
// Optional feature macro used by control_unit: CU_INSTR_COUNTER_EN.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  typedef enum logic [2:0] {
    FETCH       = 3'd0,
    DECODE      = 3'd1,
    LOAD_EXEC   = 3'd2,
    STORE_EXEC  = 3'd3,
    ALU_EXEC    = 3'd4,
    BRANCH_EXEC = 3'd5,
    HALT        = 3'd6
  } ctrl_state_type;

  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  typedef struct packed {
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;
  } ctrl_t;

  function automatic logic is_alu(
    input decoded_instruction_type i
  );
    return (i == I_MOVE) || (i == I_ADD) ||
           (i == I_SUB)  || (i == I_AND) ||
           (i == I_OR);
  endfunction

  function automatic logic is_branch(
    input decoded_instruction_type i
  );
    return (i == I_BRANCH) || (i == I_BZERO) ||
           (i == I_BNZERO) || (i == I_BNEG)  ||
           (i == I_BNNEG)  || (i == I_BOV)   ||
           (i == I_BNOV);
  endfunction

endpackage

// File: rtl/branch_eval.sv
// K&S branch condition evaluator.
// Combinational; decides whether a branch-class instruction is taken.
module branch_eval
  import k_and_s_pkg::*;
(
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    take_branch
);

  logic ovf;

  assign ovf = signed_overflow | unsigned_overflow;

  // Condition select by instruction class
  always_comb begin
    take_branch = 1'b0;
    unique case (decoded_instruction)
      I_BRANCH: take_branch = 1'b1;
      I_BZERO:  take_branch = zero_op;
      I_BNZERO: take_branch = ~zero_op;
      I_BNEG:   take_branch = neg_op;
      I_BNNEG:  take_branch = ~neg_op;
      I_BOV:    take_branch = ovf;
      I_BNOV:   take_branch = ~ovf;
      default:  take_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// K&S processor control unit: Moore FSM sequencing the datapath.
// Optional retired-instruction counter under CU_INSTR_COUNTER_EN.
module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
`ifdef CU_INSTR_COUNTER_EN
  output logic [15:0]             instr_count,
`endif
  output logic                    halt
);

  ctrl_state_type state_q;
  ctrl_state_type state_d;
  ctrl_t          ctrl;
  logic           take_branch;

  branch_eval u_branch_eval (
    .decoded_instruction (decoded_instruction),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .take_branch         (take_branch)
  );

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          decoded_instruction == I_LOAD:
            state_d = LOAD_EXEC;
          decoded_instruction == I_STORE:
            state_d = STORE_EXEC;
          is_alu(decoded_instruction):
            state_d = ALU_EXEC;
          is_branch(decoded_instruction):
            state_d = take_branch ? BRANCH_EXEC
                                  : FETCH;
          decoded_instruction == I_HALT:
            state_d = HALT;
          default:
            state_d = FETCH;
        endcase
      end
      LOAD_EXEC:   state_d = FETCH;
      STORE_EXEC:  state_d = FETCH;
      ALU_EXEC:    state_d = FETCH;
      BRANCH_EXEC: state_d = FETCH;
      HALT:        state_d = HALT;
      default:     state_d = FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Moore output decode; held at zero while reset is low so
  // strobes drop the instant rst_n falls
  always_comb begin
    ctrl = '0;
    unique case (state_q)
      FETCH: begin
        ctrl.ir_enable = 1'b1;
      end
      DECODE: begin
        ctrl.pc_enable = 1'b1;
      end
      LOAD_EXEC: begin
        ctrl.addr_sel         = 1'b1;
        ctrl.write_reg_enable = 1'b1;
      end
      STORE_EXEC: begin
        ctrl.addr_sel         = 1'b1;
        ctrl.ram_write_enable = 1'b1;
      end
      ALU_EXEC: begin
        ctrl.c_sel            = 1'b1;
        ctrl.write_reg_enable = 1'b1;
        unique case (decoded_instruction)
          I_ADD: begin
            ctrl.operation        = ALU_ADD;
            ctrl.flags_reg_enable = 1'b1;
          end
          I_SUB: begin
            ctrl.operation        = ALU_SUB;
            ctrl.flags_reg_enable = 1'b1;
          end
          I_AND: begin
            ctrl.operation        = ALU_AND;
            ctrl.flags_reg_enable = 1'b1;
          end
          I_OR: begin
            ctrl.operation        = ALU_OR;
            ctrl.flags_reg_enable = 1'b1;
          end
          default: begin
            ctrl.operation = ALU_OR;
          end
        endcase
      end
      BRANCH_EXEC: begin
        ctrl.branch    = 1'b1;
        ctrl.pc_enable = 1'b1;
        ctrl.addr_sel  = 1'b1;
      end
      HALT: begin
        ctrl.halt = 1'b1;
      end
      default: ctrl = '0;
    endcase
    if (!rst_n) ctrl = '0;
  end

  assign branch           = ctrl.branch;
  assign pc_enable        = ctrl.pc_enable;
  assign ir_enable        = ctrl.ir_enable;
  assign addr_sel         = ctrl.addr_sel;
  assign c_sel            = ctrl.c_sel;
  assign operation        = ctrl.operation;
  assign write_reg_enable = ctrl.write_reg_enable;
  assign flags_reg_enable = ctrl.flags_reg_enable;
  assign ram_write_enable = ctrl.ram_write_enable;
  assign halt             = ctrl.halt;

`ifdef CU_INSTR_COUNTER_EN
  logic [15:0] cnt_q;
  logic        retire;

  assign retire = (state_d == FETCH) &&
                  (state_q != FETCH) &&
                  (state_q != HALT);

  // Count completed instructions, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (retire && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit.
// Scoreboard of expected per-cycle control vectors.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  decoded_instruction_type di;
  logic z, n, uo, so;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable;
  logic ram_write_enable, halt;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  control_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .decoded_instruction (di),
    .zero_op             (z),
    .neg_op              (n),
    .unsigned_overflow   (uo),
    .signed_overflow     (so),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .ram_write_enable    (ram_write_enable),
    .halt                (halt)
  );

  wire [10:0] act = {branch, pc_enable, ir_enable,
                     addr_sel, c_sel, operation,
                     write_reg_enable, flags_reg_enable,
                     ram_write_enable, halt};

  function automatic logic [10:0] v(
    input logic br, input logic pc, input logic ir,
    input logic as, input logic cs, input logic [1:0] op,
    input logic wr, input logic fl, input logic rw,
    input logic h
  );
    return {br, pc, ir, as, cs, op, wr, fl, rw, h};
  endfunction

  logic [10:0] V_ZERO, V_FETCH, V_DEC, V_LOAD;
  logic [10:0] V_STORE, V_BR, V_HALT;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [10:0] alu_vec(
    input decoded_instruction_type i
  );
    case (i)
      I_ADD:   return v(0,0,0,0,1,2'b01,1,1,0,0);
      I_SUB:   return v(0,0,0,0,1,2'b10,1,1,0,0);
      I_AND:   return v(0,0,0,0,1,2'b11,1,1,0,0);
      I_OR:    return v(0,0,0,0,1,2'b00,1,1,0,0);
      default: return v(0,0,0,0,1,2'b00,1,0,0,0);
    endcase
  endfunction

  function automatic logic taken(
    input decoded_instruction_type i,
    input logic [3:0] f
  );
    // f = {z, n, uo, so}
    case (i)
      I_BRANCH: return 1'b1;
      I_BZERO:  return f[3];
      I_BNZERO: return !f[3];
      I_BNEG:   return f[2];
      I_BNNEG:  return !f[2];
      I_BOV:    return f[1] || f[0];
      I_BNOV:   return !(f[1] || f[0]);
      default:  return 1'b0;
    endcase
  endfunction

  task automatic step(input string tag);
    #1;
    if (exp_q.size() == 0)
      chk({tag, "_empty"}, 32'd1, 32'd0);
    else
      chk(tag, {21'd0, act}, {21'd0, exp_q.pop_front()});
    @(negedge clk);
  endtask

  task automatic run(input decoded_instruction_type i,
                     input logic [3:0] f);
    int cnt;
    di = i;
    {z, n, uo, so} = f;
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_DEC);
    case (i)
      I_LOAD:  exp_q.push_back(V_LOAD);
      I_STORE: exp_q.push_back(V_STORE);
      I_MOVE, I_ADD, I_SUB, I_AND, I_OR:
        exp_q.push_back(alu_vec(i));
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
      I_BNNEG, I_BOV, I_BNOV:
        if (taken(i, f)) exp_q.push_back(V_BR);
      I_HALT:
        for (int k = 0; k < 10; k++)
          exp_q.push_back(V_HALT);
      default: ;
    endcase
    cnt = exp_q.size();
    for (int k = 0; k < cnt; k++) step(i.name());
  endtask

  typedef struct {
    decoded_instruction_type i;
    logic [3:0]              f;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    V_ZERO  = '0;
    V_FETCH = v(0,0,1,0,0,2'b00,0,0,0,0);
    V_DEC   = v(0,1,0,0,0,2'b00,0,0,0,0);
    V_LOAD  = v(0,0,0,1,0,2'b00,1,0,0,0);
    V_STORE = v(0,0,0,1,0,2'b00,0,0,1,0);
    V_BR    = v(1,1,0,1,0,2'b00,0,0,0,0);
    V_HALT  = v(0,0,0,0,0,2'b00,0,0,0,1);

    tbl = '{
      '{I_ADD,    4'b0000}, '{I_MOVE,   4'b1111},
      '{I_SUB,    4'b0000}, '{I_AND,    4'b0000},
      '{I_OR,     4'b0000}, '{I_LOAD,   4'b0000},
      '{I_STORE,  4'b0000}, '{I_NOP,    4'b0000},
      '{I_BRANCH, 4'b0000}, '{I_BZERO,  4'b1000},
      '{I_BZERO,  4'b0000}, '{I_BNZERO, 4'b0000},
      '{I_BNZERO, 4'b1000}, '{I_BNEG,   4'b0100},
      '{I_BNEG,   4'b0000}, '{I_BNNEG,  4'b0100},
      '{I_BOV,    4'b0010}, '{I_BNOV,   4'b0010},
      '{I_BOV,    4'b0001}, '{I_BOV,    4'b0000},
      '{I_BNOV,   4'b0000}, '{I_ADD,    4'b1111}
    };

    rst_n = 1'b0;
    di = I_NOP;
    {z, n, uo, so} = 4'b0000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(V_ZERO);
      step("reset");
    end
    rst_n = 1'b1;

    foreach (tbl[k]) run(tbl[k].i, tbl[k].f);

    run(I_HALT, 4'b0000);

    rst_n = 1'b0;
    exp_q.push_back(V_ZERO);
    step("halt_reset");
    rst_n = 1'b1;

    di = I_STORE;
    {z, n, uo, so} = 4'b0000;
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_DEC);
    step("st_fetch");
    step("st_decode");
    #1;
    chk("st_exec", {21'd0, act}, {21'd0, V_STORE});
    #1 rst_n = 1'b0;
    #1;
    chk("st_abort", {21'd0, act}, {21'd0, V_ZERO});
    @(negedge clk);
    rst_n = 1'b1;

    run(I_NOP, 4'b0000);
    run(I_LOAD, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
